// File: rtl/mem_stage_hs.sv
// mem_stage_hs: memory-access stage with a req/ack handshake to a
// variable-latency memory. Optional MEM_TIMEOUT_EN adds a BUSY watchdog.
module mem_stage_hs #(
  parameter int          DATA_W    = 32,
  parameter int          DEST_W    = 4,
  parameter int          ADDR_W    = 16,
  parameter int unsigned BASE_ADDR = 1024
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT   = 255
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic [DATA_W-1:0] alu_res_in,
  input  logic [DATA_W-1:0] val_Rm,
  input  logic [DEST_W-1:0] dest_in,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic [DATA_W-1:0] alu_res_out,
  output logic [DEST_W-1:0] dest_out,
  output logic [DATA_W-1:0] mem_out,
  output logic              ready,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t            state;
  logic              op;
  logic [DATA_W-1:0] off;

  assign op = mem_r_en_in | mem_w_en_in;

  // Control and ALU result flow straight to writeback.
  assign wb_en_out    = wb_en_in;
  assign mem_r_en_out = mem_r_en_in;
  assign alu_res_out  = alu_res_in;
  assign dest_out     = dest_in;

  // Byte address rebased then turned into a word address.
  assign off       = alu_res_in - DATA_W'(BASE_ADDR);
  assign mem_addr  = ADDR_W'(off >> 2);
  assign mem_wdata = val_Rm;

  // Request is a pure decode of the state flop, so reset drops it at once.
  assign mem_req = (state == BUSY);
  assign mem_we  = (state == BUSY) & mem_w_en_in & ~mem_r_en_in;

  // Stall decode: only IDLE with no memory op and DONE let the pipe move.
  always_comb begin
    ready = 1'b0;
    unique case (1'b1)
      state == IDLE: ready = ~op;
      state == BUSY: ready = 1'b0;
      state == DONE: ready = 1'b1;
      default:       ready = 1'b0;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt;

  // Access sequencer with watchdog; an ack on the limit cycle still wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      mem_out <= '0;
      err     <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (op) begin
            state <= BUSY;
            cnt   <= '0;
            err   <= 1'b0;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            if (mem_r_en_in) mem_out <= mem_rdata;
            state <= DONE;
          end else if (cnt == LAST) begin
            if (mem_r_en_in) mem_out <= '0;
            err   <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign err = 1'b0;

  // Access sequencer: BUSY waits as long as the memory needs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      mem_out <= '0;
    end else begin
      case (state)
        IDLE: if (op) state <= BUSY;
        BUSY: begin
          if (mem_ack) begin
            if (mem_r_en_in) mem_out <= mem_rdata;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage_hs.sv
// tb_mem_stage_hs: scoreboard bench for mem_stage_hs.
// Expected load data is queued at issue and popped in DONE.
module tb_mem_stage_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in;
  logic [31:0] alu_res_in, val_Rm;
  logic [3:0]  dest_in;
  logic        wb_en_out, mem_r_en_out;
  logic [31:0] alu_res_out;
  logic [3:0]  dest_out;
  logic [31:0] mem_out;
  logic        ready, err;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_out = '0;
  logic        exp_err = 1'b0;

`ifdef MEM_TIMEOUT_EN
  localparam int TMO = 4;
  mem_stage_hs #(.TIMEOUT(TMO)) dut (
`else
  mem_stage_hs dut (
`endif
    .clk(clk), .rst(rst),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .alu_res_in(alu_res_in),
    .val_Rm(val_Rm), .dest_in(dest_in),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .alu_res_out(alu_res_out), .dest_out(dest_out),
    .mem_out(mem_out), .ready(ready), .err(err),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one access; lat = BUSY cycle carrying the ack (0 = never ack).
  // Called just after a rising edge with the DUT in IDLE.
  task automatic mem_op(input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int lat);
    int lows, busy, cyc, exp_lows;
    logic [31:0] eaddr;
    mem_r_en_in = r;
    mem_w_en_in = w;
    alu_res_in  = a;
    val_Rm      = wd;
    eaddr = (a - 32'd1024) >> 2;
    if (r) model_out = (lat == 0) ? 32'd0 : rd;
    exp_err = (lat == 0);
    exp_q.push_back(model_out);
`ifdef MEM_TIMEOUT_EN
    exp_lows = (lat == 0) ? TMO + 1 : lat + 1;
`else
    exp_lows = lat + 1;
`endif
    lows = 0; busy = 0; cyc = 0;
    @(negedge clk);
    check("idle_req", {31'd0, mem_req}, 32'd0);
    while (!ready && cyc < 40) begin
      lows++;
      if (mem_req) begin
        busy++;
        if (busy == 1) begin
          check("addr", {16'd0, mem_addr}, {16'd0, eaddr[15:0]});
          check("we", {31'd0, mem_we}, {31'd0, w & ~r});
          check("wdata", mem_wdata, wd);
        end
        if (busy == lat) begin
          mem_ack   = 1'b1;
          mem_rdata = rd;
        end
      end
      @(posedge clk);
      #1 mem_ack = 1'b0;
      mem_rdata = $urandom;
      cyc++;
      @(negedge clk);
    end
    check("stall_len", lows, exp_lows);
    check("done_ready", {31'd0, ready}, 32'd1);
    check("done_req", {31'd0, mem_req}, 32'd0);
    check("err", {31'd0, err}, {31'd0, exp_err});
    if (exp_q.size() != 0)
      check("mem_out", mem_out, exp_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  // Non-memory traffic: one cycle per op, no requests, pass-through live.
  task automatic idle_chk(input int n);
    mem_r_en_in = 1'b0;
    mem_w_en_in = 1'b0;
    wb_en_in    = 1'b1;
    dest_in     = 4'd5;
    for (int i = 0; i < n; i++) begin
      alu_res_in = 32'd77 + i;
      @(negedge clk);
      check("np_ready", {31'd0, ready}, 32'd1);
      check("np_req", {31'd0, mem_req}, 32'd0);
      check("np_wb", {31'd0, wb_en_out}, 32'd1);
      check("np_dest", {28'd0, dest_out}, 32'd5);
      check("np_alu", alu_res_out, 32'd77 + i);
      check("np_hold", mem_out, model_out);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b0;
    wb_en_in = 1'b0; mem_w_en_in = 1'b0;
    mem_r_en_in = 1'b1; alu_res_in = 32'd1032;
    val_Rm = '0; dest_in = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_out", mem_out, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rel_req", {31'd0, mem_req}, 32'd1);
    #1 rst = 1'b0;
    #1 check("async_drop", {31'd0, mem_req}, 32'd0);
    mem_r_en_in = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'hBAD0BAD0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 mem_ack = 1'b0;
    @(negedge clk);
    check("stray_ack", mem_out, 32'd0);
    @(posedge clk);
    #1;

    mem_op(1'b1, 1'b0, 32'd1032, 32'd0, 32'hDEADBEEF, 2);
    mem_op(1'b0, 1'b1, 32'd1024, 32'h12345678, 32'hFFFF0000, 1);
    idle_chk(3);
    mem_op(1'b1, 1'b0, 32'd1100, 32'd0, 32'hA5A5A5A5, 1);
    mem_op(1'b1, 1'b0, 32'd0, 32'd0, 32'h0BADF00D, 1);
    mem_op(1'b1, 1'b1, 32'd2048, 32'h55AA55AA, 32'hC001D00D, 3);
    mem_op(1'b0, 1'b1, 32'd1028, 32'h9ABCDEF0, 32'h11111111, 5);
    idle_chk(2);
`ifdef MEM_TIMEOUT_EN
    mem_op(1'b1, 1'b0, 32'd1040, 32'd0, 32'h77777777, 0);
    mem_op(1'b1, 1'b0, 32'd1044, 32'd0, 32'h13579BDF, 4);
`endif
    mem_op(1'b1, 1'b0, 32'd1036, 32'd0, 32'h2468ACE0, 1);
    idle_chk(1);
    check("q_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
